// File: rtl/acc4_pkg.sv
// acc4_pkg: shared definitions for the acc4_unit accumulator stage.
//   ACC_W       accumulator / operand width (fixed at 4)
//   acc4_op_e   operation encoding carried on in_op
//   *_RST       reset values for the accumulator and flags
package acc4_pkg;

   localparam int unsigned ACC_W = 4;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ADD  = 2'b01,
      OP_ADC  = 2'b10,
      OP_CLR  = 2'b11
   } acc4_op_e;

   localparam logic [ACC_W-1:0] ACC_RST    = '0;
   localparam logic             FLAG_C_RST = 1'b0;
   localparam logic             FLAG_Z_RST = 1'b1;
   localparam logic             FLAG_V_RST = 1'b0;

endpackage

// File: rtl/acc4_adder.sv
// acc4_adder: purely combinational ACC_W-bit add with carry-in.
//   a, b  in   ACC_W  operands
//   cin   in   1      carry in
//   sum   out  ACC_W  a + b + cin, modulo 2**ACC_W
//   cout  out  1      unsigned carry out
//   ovf   out  1      two's-complement overflow
module acc4_adder
   import acc4_pkg::*;
(
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   input  logic             cin,
   output logic [ACC_W-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [ACC_W:0] full;

   always_comb begin
      full = {1'b0, a} + {1'b0, b} + {{ACC_W{1'b0}}, cin};
      sum  = full[ACC_W-1:0];
      cout = full[ACC_W];
      // Overflow when both operands share a sign and the result's sign differs.
      ovf  = (a[ACC_W-1] == b[ACC_W-1]) && (full[ACC_W-1] != a[ACC_W-1]);
   end

endmodule

// File: rtl/acc4_unit.sv
// acc4_unit: 4-bit accumulator stage with carry/zero/overflow flags and a
// one-entry valid/ready output register with pass-through ready.
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operation request
//   in_ready   out  1      operation can be accepted this cycle
//   in_op      in   2      00 LOAD, 01 ADD, 10 ADC, 11 CLR
//   in_data    in   ACC_W  operand (ignored for CLR)
//   out_valid  out  1      acc/flags hold an unconsumed result
//   out_ready  in   1      consumer takes the result
//   acc        out  ACC_W  accumulator value
//   flag_c     out  1      carry out of last ADD/ADC
//   flag_z     out  1      acc == 0
//   flag_v     out  1      signed overflow of last ADD/ADC
// Build option: define ACC4_SATURATE_EN to clamp ADD/ADC to all-ones on
// unsigned carry-out instead of wrapping.
module acc4_unit
   import acc4_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [ACC_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_v
);

   acc4_op_e         op;
   logic             accept;
   logic             add_cin;
   logic [ACC_W-1:0] add_sum;
   logic             add_cout;
   logic             add_ovf;
   logic [ACC_W-1:0] nxt_acc;
   logic             nxt_c;
   logic             nxt_z;
   logic             nxt_v;

   assign op       = acc4_op_e'(in_op);
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign add_cin  = (op == OP_ADC) ? flag_c : 1'b0;

   acc4_adder u_adder (
      .a    (acc),
      .b    (in_data),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout),
      .ovf  (add_ovf)
   );

   always_comb begin
      nxt_acc = acc;
      nxt_c   = flag_c;
      nxt_v   = flag_v;
      case (op)
         OP_LOAD: begin
            nxt_acc = in_data;
            nxt_c   = 1'b0;
            nxt_v   = 1'b0;
         end
         OP_ADD, OP_ADC: begin
            nxt_c = add_cout;
            nxt_v = add_ovf;
`ifdef ACC4_SATURATE_EN
            // V still reflects the unclamped sum; only acc is clamped.
            nxt_acc = add_cout ? '1 : add_sum;
`else
            nxt_acc = add_sum;
`endif
         end
         OP_CLR: begin
            nxt_acc = '0;
            nxt_c   = 1'b0;
            nxt_v   = 1'b0;
         end
      endcase
      nxt_z = (nxt_acc == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= ACC_RST;
         flag_c    <= FLAG_C_RST;
         flag_z    <= FLAG_Z_RST;
         flag_v    <= FLAG_V_RST;
         out_valid <= 1'b0;
      end else if (accept) begin
         acc       <= nxt_acc;
         flag_c    <= nxt_c;
         flag_z    <= nxt_z;
         flag_v    <= nxt_v;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_acc4_unit.sv
module tb_acc4_unit;

   typedef struct packed {
      logic [3:0] acc;
      logic       c;
      logic       z;
      logic       v;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_op;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] acc;
   logic       flag_c;
   logic       flag_z;
   logic       flag_v;

   int unsigned n_checks = 0;
   int unsigned n_passed = 0;

   res_t q[$];
   res_t m_st;
   logic m_ov;
   logic rand_rdy = 1'b0;

   acc4_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc       (acc),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .flag_v    (flag_v)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got == exp) n_passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Reference arithmetic done in plain integers, including signed overflow.
   function automatic res_t model_op(input logic [1:0] op, input logic [3:0] d, input res_t st);
      res_t r;
      int   s;
      int   sa;
      int   sd;
      int   sv;
      int   cin;
      r = st;
      case (op)
         2'b00: begin r.acc = d; r.c = 1'b0; r.v = 1'b0; end
         2'b11: begin r.acc = 4'd0; r.c = 1'b0; r.v = 1'b0; end
         default: begin
            cin  = (op == 2'b10) ? int'(st.c) : 0;
            s    = int'(st.acc) + int'(d) + cin;
            sa   = (st.acc > 4'd7) ? int'(st.acc) - 16 : int'(st.acc);
            sd   = (d > 4'd7) ? int'(d) - 16 : int'(d);
            sv   = sa + sd + cin;
            r.v  = (sv > 7) || (sv < -8);
            r.c  = (s > 15);
            r.acc = 4'(s % 16);
`ifdef ACC4_SATURATE_EN
            if (s > 15) r.acc = 4'd15;
`endif
         end
      endcase
      r.z = (r.acc == 4'd0);
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_ov <= 1'b0;
         m_st <= '{acc: 4'd0, c: 1'b0, z: 1'b1, v: 1'b0};
      end else if (in_valid && (!m_ov || out_ready)) begin
         q.push_back(model_op(in_op, in_data, m_st));
         m_st <= model_op(in_op, in_data, m_st);
         m_ov <= 1'b1;
      end else if (out_ready) begin
         m_ov <= 1'b0;
      end
   end

   always @(negedge clk) begin
      res_t r;
      if (!rst) begin
         check_eq("in_ready", in_ready, !m_ov || out_ready);
         check_eq("out_valid", out_valid, m_ov);
         check_eq("hold_acc", acc, m_st.acc);
         check_eq("hold_flags", {flag_c, flag_z, flag_v}, {m_st.c, m_st.z, m_st.v});
         if (out_valid && out_ready) begin
            check_eq("sb_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
               r = q.pop_front();
               check_eq("sb_acc", acc, r.acc);
               check_eq("sb_c", flag_c, r.c);
               check_eq("sb_z", flag_z, r.z);
               check_eq("sb_v", flag_v, r.v);
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #2;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [1:0] op, input logic [3:0] d);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!m_ov || out_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("accept", ok, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic check_state(input string tag, input logic [3:0] a, input logic c, input logic z, input logic v);
      check_eq({tag, "_acc"}, acc, a);
      check_eq({tag, "_czv"}, {flag_c, flag_z, flag_v}, {c, z, v});
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_op     = 2'b00;
      in_data   = 4'd9;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_state("reset", 4'd0, 1'b0, 1'b1, 1'b0);
      check_eq("reset_ov", out_valid, 0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;

      send(2'b00, 4'd7);
      @(negedge clk);
      check_state("load7", 4'd7, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      send(2'b01, 4'd9);
      @(negedge clk);
      check_state("add9", 4'd0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check_eq("ov_pulse", out_valid, 0);
      @(posedge clk);
      #1;

      send(2'b00, 4'd15);
      send(2'b01, 4'd1);
      @(negedge clk);
`ifdef ACC4_SATURATE_EN
      check_state("add15p1", 4'd15, 1'b1, 1'b0, 1'b0);
`else
      check_state("add15p1", 4'd0, 1'b1, 1'b1, 1'b0);
`endif
      @(posedge clk);
      #1;
      send(2'b10, 4'd0);
      @(negedge clk);
`ifdef ACC4_SATURATE_EN
      check_state("adc0", 4'd15, 1'b1, 1'b0, 1'b0);
`else
      check_state("adc0", 4'd1, 1'b0, 1'b0, 1'b0);
`endif
      @(posedge clk);
      #1;

      send(2'b00, 4'd7);
      send(2'b01, 4'd1);
      @(negedge clk);
      check_state("ovf", 4'd8, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      send(2'b00, 4'd15);
      send(2'b01, 4'd2);
      @(negedge clk);
`ifdef ACC4_SATURATE_EN
      check_state("sat", 4'd15, 1'b1, 1'b0, 1'b0);
`else
      check_state("wrap", 4'd1, 1'b1, 1'b0, 1'b0);
`endif
      @(posedge clk);
      #1;

      // Backpressure: stalled result, next op held on the input.
      out_ready = 1'b0;
      send(2'b00, 4'd5);
      in_valid = 1'b1;
      in_op    = 2'b01;
      in_data  = 4'd2;
      repeat (5) begin
         @(negedge clk);
         check_eq("stall_in_ready", in_ready, 0);
         check_eq("stall_ov", out_valid, 1);
         check_state("stall", 4'd5, 1'b0, 1'b0, 1'b0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("release_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_state("release", 4'd7, 1'b0, 1'b0, 1'b0);
      check_eq("release_ov", out_valid, 1);
      @(posedge clk);
      #1;

      // Reset while a result is stalled.
      out_ready = 1'b0;
      send(2'b00, 4'd9);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_state("rst_stall", 4'd0, 1'b0, 1'b1, 1'b0);
      check_eq("rst_stall_ov", out_valid, 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Back-to-back LOAD 3, ADD 4, CLR.
      send(2'b00, 4'd3);
      send(2'b01, 4'd4);
      send(2'b11, 4'd6);
      @(negedge clk);
      check_state("b2b_clr", 4'd0, 1'b0, 1'b1, 1'b0);

      // Random ops with random consumer backpressure.
      @(posedge clk);
      #1;
      rand_rdy = 1'b1;
      repeat (60) begin
         if ($urandom_range(0, 3) != 0)
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
         else begin
            @(posedge clk);
            #1;
         end
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #3;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("sb_drain", q.size(), 0);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/acc4_unit.md
# acc4_unit

4-bit accumulator stage directly downstream of the 4-bit ripple adder in the notes CPU datapath. Each accepted operation combines an input operand with the accumulator register through that adder and registers the result with carry, zero and overflow flags. The flagged result is presented on a valid/ready output handshake. Carry-chained ADC lets software build wider sums one nibble at a time.

## Interface
Parameters:
- none. Width is fixed at 4 by the package constant `ACC_W`.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operation request
- `in_ready`  out  1  block can accept an operation this cycle
- `in_op`  in  2  00 LOAD, 01 ADD (Cin=0), 10 ADC (Cin=flag_c), 11 CLR
- `in_data`  in  4  operand; ignored for CLR
- `out_valid`  out  1  `acc`/flags hold an unconsumed result
- `out_ready`  in  1  consumer takes the result
- `acc`  out  4  accumulator value
- `flag_c`  out  1  carry out of last ADD/ADC
- `flag_z`  out  1  `acc == 0`
- `flag_v`  out  1  signed (two's-complement) overflow of last ADD/ADC

## Operation
- Accept condition: `in_valid && in_ready` at a rising edge.
- `in_ready = !out_valid || out_ready`. This is a one-entry output register with pass-through ready.
- LOAD:
  - `acc <= in_data`.
  - C and V cleared.
  - Z recomputed.
- ADD:
  - `{C, acc} <= acc + in_data + 0`, computed in 5 bits.
  - `V = (acc[3] == in_data[3]) && (sum[3] != acc[3])`.
  - Z is taken from the new acc.
- ADC: same as ADD, with Cin = current `flag_c`.
- CLR:
  - acc = 0, C = 0, V = 0, Z = 1.
- Every accepted op sets `out_valid <= 1`.
- Output handshake: `out_valid && out_ready` with no accept clears `out_valid`.
- Accept and output handshake in the same cycle: `out_valid` stays 1 and the new result replaces the old one.
- Without an accept, `acc` and all flags hold their values, including across output handshakes.
- Arithmetic wraps modulo 16: 15+1 gives acc=0, C=1, Z=1.

## Timing
- Latency: 1 cycle. An op accepted at edge N is visible on `acc`/flags, with `out_valid`=1, after edge N.
- Throughput: 1 op/cycle while `out_ready` is held high.
- Output stall: with `out_valid`=1 and `out_ready`=0, `in_ready`=0 and all outputs are held stable.
- Reset values, applied at the first edge with `rst`=1:
  - acc = 0, flag_c = 0, flag_z = 1, flag_v = 0
  - out_valid = 0
  - `in_ready` = 1 once `rst` deasserts
- Reset overrides any simultaneous accept.
- Reset mid-stall drops the pending result.
- `in_ready` is combinational from `out_valid`/`out_ready`. There is no combinational path from `in_valid` to `in_ready`.

## Configuration
- Macro: `ACC4_SATURATE_EN`.
- Defined: ADD/ADC clamp on unsigned carry-out.
  - acc = 4'hF, flag_c = 1.
  - flag_v is computed from the unclamped sum.
  - Z reflects the clamped acc.
- Undefined: modulo-16 wrap exactly as in Operation.
- LOAD and CLR behave the same in both builds.

## Structure
- Package `acc4_pkg` holds:
  - `ACC_W = 4`
  - enum `acc4_op_e` {`OP_LOAD`, `OP_ADD`, `OP_ADC`, `OP_CLR`}, encoded 2'b00..2'b11
  - reset constants for acc and flags
- Sub-module `acc4_adder`: purely combinational 4-bit add.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, ovf.
  - It is instantiated once. All state stays in `acc4_unit`.

## Test plan
- Reset, then LOAD 7, then ADD 9 with `out_ready`=1:
  - After LOAD: acc=7, Z=0.
  - After ADD: acc=0, C=1, Z=1, V=0.
  - `out_valid` pulses one cycle per op.
- ADD 15+1 followed by ADC 0:
  - After ADD: acc=0, C=1.
  - After ADC: acc=1, C=0.
  - Confirms the carry chain.
- Signed overflow, LOAD 7 then ADD 1:
  - acc=8, V=1, C=0.
  - With `ACC4_SATURATE_EN`, LOAD 15 then ADD 2 gives acc=15, C=1.
- Backpressure: hold `out_ready`=0 after one op.
  - `in_ready`=0 and outputs stay stable for 5 cycles while `in_valid` is held.
  - Raising `out_ready` accepts the held op in that same cycle.
- Assert `rst` while a result is stalled:
  - acc=0, Z=1, C=0, V=0, `out_valid`=0 on the next edge.
- Back-to-back LOAD 3, ADD 4, CLR with `out_ready`=1:
  - Results are 3, 7, 0 on consecutive cycles.
  - `in_ready` stays 1 throughout.
